// File: rtl/md5_msg_padder.sv
// Builds a single padded MD5 block from a short plaintext word (0..16 bytes),
// one plaintext byte per cycle, then holds it until the hash core accepts it.
module md5_msg_padder (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] word_in,
  input  logic [4:0]   word_in_width,
  input  logic         word_valid,
  output logic         word_ready,
  output logic [511:0] block_out,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         width_err,
  output logic [15:0]  blocks_sent
);

  // state | meaning
  // IDLE  | waiting for a word, word_ready high
  // FILL  | copying plaintext byte i into block byte i
  // PAD   | writing the 0x80 marker and the bit length
  // VALID | block presented, waiting for block_ready
  typedef enum logic [1:0] {IDLE, FILL, PAD, VALID} state_t;

  state_t        state;
  logic [127:0]  word_q;
  logic [4:0]    w_q;
  logic [4:0]    i_q;
  logic [4:0]    src_idx;
  logic [127:0]  src_shift;
  logic [7:0]    src_byte;

  // Plaintext is right-justified: byte i sits (w-1-i) bytes above the LSB.
  assign src_idx   = w_q - i_q - 5'd1;
  assign src_shift = word_q >> {src_idx, 3'b000};
  assign src_byte  = src_shift[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      word_q      <= '0;
      w_q         <= '0;
      i_q         <= '0;
      block_out   <= '0;
      block_valid <= 1'b0;
      width_err   <= 1'b0;
      word_ready  <= 1'b1;
      blocks_sent <= '0;
    end else begin
      width_err <= 1'b0;
      case (state)
        IDLE: begin
          if (word_valid && word_ready) begin
            if (word_in_width > 5'd16) begin
              width_err <= 1'b1;
            end else begin
              word_q     <= word_in;
              w_q        <= word_in_width;
              i_q        <= '0;
              block_out  <= '0;
              word_ready <= 1'b0;
              state      <= (word_in_width == 5'd0) ? PAD : FILL;
            end
          end
        end
        FILL: begin
          block_out[{i_q[3:0], 3'b000} +: 8] <= src_byte;
          i_q <= i_q + 5'd1;
          if (i_q == w_q - 5'd1) state <= PAD;
        end
        PAD: begin
          // Bit length is at most 128, so only byte 56 of the length is non-zero.
          block_out[{w_q, 3'b000} +: 8] <= 8'h80;
          block_out[455:448]            <= {w_q, 3'b000};
          block_out[511:456]            <= '0;
          state                         <= VALID;
        end
        VALID: begin
          if (block_valid && block_ready) begin
            block_valid <= 1'b0;
            word_ready  <= 1'b1;
            blocks_sent <= blocks_sent + 16'd1;
            state       <= IDLE;
          end else begin
            block_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// Randomized and directed checks of md5_msg_padder against a byte-array model
// of the padding rules.
module tb_md5_msg_padder;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] word_in;
  logic [4:0]   word_in_width;
  logic         word_valid;
  logic         word_ready;
  logic [511:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic         width_err;
  logic [15:0]  blocks_sent;

  int tests = 0;
  int fails = 0;

  logic        mon_on = 1'b0;
  logic        exp_ready;
  logic        exp_err;
  logic [15:0] exp_count;
  logic [511:0] last_blk;

  md5_msg_padder dut (
    .clk(clk), .reset(reset), .word_in(word_in), .word_in_width(word_in_width),
    .word_valid(word_valid), .word_ready(word_ready), .block_out(block_out),
    .block_valid(block_valid), .block_ready(block_ready), .width_err(width_err),
    .blocks_sent(blocks_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Padding rules expressed as a list of 64 bytes.
  function automatic logic [511:0] model(input logic [127:0] w, input int n);
    logic [7:0]  b [64];
    logic [63:0] bits;
    logic [127:0] t;
    logic [511:0] r;
    for (int k = 0; k < 64; k++) b[k] = 8'h00;
    for (int k = 0; k < n; k++) begin
      t = w >> (8 * (n - 1 - k));
      b[k] = t[7:0];
    end
    b[n] = 8'h80;
    bits = 64'(n) * 64'd8;
    for (int k = 0; k < 8; k++) b[56 + k] = 8'(bits >> (8 * k));
    for (int k = 0; k < 64; k++) r[8*k +: 8] = b[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("word_ready", 512'(word_ready), 512'(exp_ready));
      chk("width_err", 512'(width_err), 512'(exp_err));
      chk("blocks_sent", 512'(blocks_sent), 512'(exp_count));
    end
  end

  task automatic run_txn(input logic [127:0] w, input int n, input int delay);
    logic [511:0] exp_blk;
    exp_blk       = model(w, n);
    word_in       = w;
    word_in_width = 5'(n);
    word_valid    = 1'b1;
    tick();
    exp_ready     = 1'b0;
    word_valid    = 1'b0;
    for (int k = 1; k <= n + 1; k++) begin
      word_in       = {$urandom, $urandom, $urandom, $urandom};
      word_in_width = 5'($urandom);
      word_valid    = 1'($urandom);
      block_ready   = 1'($urandom);
      tick();
      chk("latency_early", 512'(block_valid), 512'(0));
    end
    block_ready = 1'b0;
    tick();
    chk("latency_valid", 512'(block_valid), 512'(1));
    chk("block_out", block_out, exp_blk);
    last_blk = block_out;
    for (int d = 0; d < delay; d++) begin
      word_valid    = 1'($urandom);
      word_in_width = 5'($urandom);
      tick();
      chk("hold_valid", 512'(block_valid), 512'(1));
      chk("hold_block", block_out, exp_blk);
    end
    word_valid  = 1'b0;
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    exp_ready   = 1'b1;
    exp_count   = exp_count + 16'd1;
    chk("accept_drop", 512'(block_valid), 512'(0));
  endtask

  task automatic bad_width(input int n);
    word_in       = {$urandom, $urandom, $urandom, $urandom};
    word_in_width = 5'(n);
    word_valid    = 1'b1;
    tick();
    word_valid = 1'b0;
    exp_err    = 1'b1;
    tick();
    exp_err    = 1'b0;
    chk("err_no_block", 512'(block_valid), 512'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    exp_ready = 1'b1;
    exp_err   = 1'b0;
    exp_count = '0;
  endtask

  initial begin
    word_in = '0; word_in_width = '0; word_valid = 1'b0; block_ready = 1'b0;
    exp_ready = 1'b1; exp_err = 1'b0; exp_count = '0; reset = 1'b1;
    tick();
    do_reset();
    mon_on = 1'b1;
    chk("reset_block", block_out, 512'(0));
    chk("reset_valid", 512'(block_valid), 512'(0));

    run_txn(128'h616B6861, 4, 0);
    chk("akha_low", 512'(last_blk[39:0]), 512'(40'h80_61_68_6B_61));
    chk("akha_len", 512'(last_blk[455:448]), 512'(8'h20));
    chk("akha_rest", 512'({last_blk[511:456], last_blk[447:40]}), 512'(0));

    run_txn(128'h0, 0, 1);
    chk("w0_block", last_blk, 512'(8'h80));

    run_txn(128'h000102030405060708090A0B0C0D0E0F, 16, 0);
    chk("w16_b0", 512'(last_blk[7:0]), 512'(8'h00));
    chk("w16_b15", 512'(last_blk[127:120]), 512'(8'h0F));
    chk("w16_b16", 512'(last_blk[135:128]), 512'(8'h80));
    chk("w16_b56", 512'(last_blk[455:448]), 512'(8'h80));
    chk("w16_b57", 512'(last_blk[463:456]), 512'(8'h00));

    bad_width(17);
    bad_width(31);

    run_txn({$urandom, $urandom, $urandom, $urandom}, 7, 10);

    // Abort a block mid-fill with a competing capture request.
    word_in = {$urandom, $urandom, $urandom, $urandom};
    word_in_width = 5'd8;
    word_valid = 1'b1;
    tick();
    exp_ready = 1'b0;
    word_valid = 1'b0;
    tick(); tick(); tick();
    word_valid = 1'b1;
    block_ready = 1'b1;
    do_reset();
    word_valid = 1'b0;
    block_ready = 1'b0;
    chk("abort_block", block_out, 512'(0));
    chk("abort_valid", 512'(block_valid), 512'(0));

    run_txn(128'h616B6861, 4, 2);
    chk("akha2_low", 512'(last_blk[39:0]), 512'(40'h80_61_68_6B_61));

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 5) == 0) bad_width($urandom_range(17, 31));
      else run_txn({$urandom, $urandom, $urandom, $urandom},
                   $urandom_range(0, 16), $urandom_range(0, 3));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
